// File: rtl/ccu_pkg.sv
// Shared types and defaults for the clock control unit.
// The macro CCU_PROTO_CHK_EN enables the handshake protocol checker in ccu_clk_ctrl.
package ccu_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        SLEEP = 2'd3
    } ccu_state_e;

    localparam int unsigned CCU_NUM_SLICES    = 7;
    localparam int unsigned CCU_ACK_DLY       = 20;
    localparam int unsigned CCU_DEASSERT_DLY  = 30;
    localparam int unsigned CCU_CLK_DIV       = 1;
    localparam int unsigned CCU_USYNC_PERIOD  = 16;

    // Bits needed to hold the values 0..max_val-1.
    function automatic int unsigned ccu_cnt_w(input int unsigned max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/ccu_slice.sv
// One clock slice: request FSM, wake/sleep delay counter, divider and
// flop-based clock gate.
module ccu_slice
    import ccu_pkg::*;
#(
    parameter int unsigned ACK_DLY      = CCU_ACK_DLY,
    parameter int unsigned DEASSERT_DLY = CCU_DEASSERT_DLY,
    parameter int unsigned CLK_DIV      = CCU_CLK_DIV,
    parameter int unsigned CW           = 5,
    parameter int unsigned DW           = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkreq,
    input  logic       global_rst_b,
    input  logic       pwell_pok,
    output logic       slice_clk,
    output logic       clkack,
    output ccu_state_e state
);

    logic          eff_req;
    logic          div_en;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;

    assign eff_req = pwell_pok & (clkreq | ~global_rst_b);
    // A high phase is always completed, so the clock only ever stops low.
    assign div_en  = (state == ON) | slice_clk;

    always_ff @(posedge clk) begin
        if (rst || !pwell_pok) begin
            state     <= OFF;
            cnt       <= '0;
            div       <= '0;
            slice_clk <= 1'b0;
            clkack    <= 1'b0;
        end else begin
            if (div_en) begin
                if (div == DW'(CLK_DIV - 1)) begin
                    div       <= '0;
                    slice_clk <= ~slice_clk;
                end else begin
                    div <= div + DW'(1);
                end
            end

            // Transitions always run to completion; a changed request is
            // picked up from the following stable state.
            case (state)
                OFF: begin
                    if (eff_req) begin
                        state <= WAKE;
                        cnt   <= CW'(ACK_DLY - 1);
                    end
                end
                WAKE: begin
                    if (cnt == '0) begin
                        state  <= ON;
                        clkack <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ON: begin
                    if (!eff_req) begin
                        state <= SLEEP;
                        cnt   <= CW'(DEASSERT_DLY - 1);
                    end
                end
                SLEEP: begin
                    if (cnt == '0) begin
                        state  <= OFF;
                        clkack <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: rtl/ccu_clk_ctrl.sv
// Clock control unit: NUM_SLICES independent slices, shared usync counter.
// Define CCU_PROTO_CHK_EN to build the sticky clkreq protocol checker.
module ccu_clk_ctrl
    import ccu_pkg::*;
#(
    parameter int unsigned NUM_SLICES   = CCU_NUM_SLICES,
    parameter int unsigned ACK_DLY      = CCU_ACK_DLY,
    parameter int unsigned DEASSERT_DLY = CCU_DEASSERT_DLY,
    parameter int unsigned CLK_DIV      = CCU_CLK_DIV,
    parameter int unsigned USYNC_PERIOD = CCU_USYNC_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SLICES-1:0] clkreq,
    input  logic [NUM_SLICES-1:0] global_rst_b,
    input  logic [NUM_SLICES-1:0] pwell_pok,
    output logic [NUM_SLICES-1:0] slice_clk,
    output logic [NUM_SLICES-1:0] clkack,
    output logic [NUM_SLICES-1:0] usync,
    output logic                  proto_err
);

    localparam int unsigned MAX_DLY = (ACK_DLY > DEASSERT_DLY) ? ACK_DLY : DEASSERT_DLY;
    localparam int unsigned CW      = ccu_cnt_w(MAX_DLY);
    localparam int unsigned DW      = ccu_cnt_w(CLK_DIV);
    localparam int unsigned UW      = ccu_cnt_w(USYNC_PERIOD);

    ccu_state_e            st [NUM_SLICES];
    logic [NUM_SLICES-1:0] on_vec;
    logic [UW-1:0]         ucnt;

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        ccu_slice #(
            .ACK_DLY      (ACK_DLY),
            .DEASSERT_DLY (DEASSERT_DLY),
            .CLK_DIV      (CLK_DIV),
            .CW           (CW),
            .DW           (DW)
        ) u_slice (
            .clk          (clk),
            .rst          (rst),
            .clkreq       (clkreq[i]),
            .global_rst_b (global_rst_b[i]),
            .pwell_pok    (pwell_pok[i]),
            .slice_clk    (slice_clk[i]),
            .clkack       (clkack[i]),
            .state        (st[i])
        );
        assign on_vec[i] = (st[i] == ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt  <= '0;
            usync <= '0;
        end else if (ucnt == UW'(USYNC_PERIOD - 1)) begin
            ucnt  <= '0;
            usync <= on_vec;
        end else begin
            ucnt  <= ucnt + UW'(1);
            usync <= '0;
        end
    end

`ifdef CCU_PROTO_CHK_EN
    logic [NUM_SLICES-1:0] req_q;
    logic [NUM_SLICES-1:0] viol;

    // clkreq must hold steady through a transition and must not drop while
    // the slice is already off and powered.
    always_comb begin
        viol = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            viol[i] = (((st[i] == WAKE) || (st[i] == SLEEP)) && (clkreq[i] != req_q[i]))
                    || ((st[i] == OFF) && pwell_pok[i] && req_q[i] && !clkreq[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            req_q <= clkreq;
            if (|viol) proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccu_clk_ctrl.sv
// Directed bench for ccu_clk_ctrl: a vector table plus hand-written
// latency, power-override, usync and protocol-check sequences.
module tb_ccu_clk_ctrl;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] clkreq, global_rst_b, pwell_pok;
    logic [N-1:0] slice_clk, clkack, usync;
    logic         proto_err;

    int nchk = 0;
    int nerr = 0;

    ccu_clk_ctrl #(
        .NUM_SLICES   (N),
        .ACK_DLY      (20),
        .DEASSERT_DLY (30),
        .CLK_DIV      (1),
        .USYNC_PERIOD (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clkreq       (clkreq),
        .global_rst_b (global_rst_b),
        .pwell_pok    (pwell_pok),
        .slice_clk    (slice_clk),
        .clkack       (clkack),
        .usync        (usync),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grb;
        logic [N-1:0] pok;
        int           ncyc;
        logic [N-1:0] ack;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps until clkack[idx]==val; returns the step count (== bound on timeout).
    task automatic cnt_until(input int idx, input logic val, input int bound, output int n);
        n = 0;
        while (clkack[idx] !== val && n < bound) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int tot;
        logic ok;

        // ---- vector table (slices 1, 2, 4), starting from all-off ----
        tbl[0] = '{7'h00, 7'h7F, 7'h7F, 5,  7'h00};
        tbl[1] = '{7'h12, 7'h7F, 7'h7F, 25, 7'h12};  // slices 1,4 wake
        tbl[2] = '{7'h12, 7'h7B, 7'h7F, 21, 7'h16};  // grb[2] low forces slice 2 on
        tbl[3] = '{7'h12, 7'h7B, 7'h7D, 1,  7'h14};  // pok[1] low kills slice 1 at once
        tbl[4] = '{7'h12, 7'h7B, 7'h7F, 20, 7'h14};  // one cycle short of ack
        tbl[5] = '{7'h12, 7'h7B, 7'h7F, 1,  7'h16};
        tbl[6] = '{7'h12, 7'h7F, 7'h7F, 30, 7'h16};  // one cycle short of sleep done
        tbl[7] = '{7'h12, 7'h7F, 7'h7F, 1,  7'h12};
        tbl[8] = '{7'h12, 7'h7F, 7'h00, 1,  7'h00};  // all power lost

        rst          = 1'b1;
        clkreq       = '0;
        global_rst_b = '1;
        pwell_pok    = '1;
        repeat (3) step();
        chk("reset_clkack", 32'(clkack), 32'h0);
        chk("reset_slice_clk", 32'(slice_clk), 32'h0);
        chk("reset_usync", 32'(usync), 32'h0);
        chk("reset_proto_err", 32'(proto_err), 32'h0);
        rst = 1'b0;

        // ---- slice 0 wake latency and clock toggling ----
        clkreq[0] = 1'b1;
        step();
        cnt_until(0, 1'b1, 40, n);
        chk("s0_ack_latency", 32'(n), 32'd20);
        chk("s0_clk_low_at_ack", 32'(slice_clk[0]), 32'h0);
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (slice_clk[0] !== ~k[0]) ok = 1'b0;
        end
        chk("s0_clk_toggle", 32'(ok), 32'h1);

        // ---- slice 0 sleep latency, clock stays low ----
        clkreq[0] = 1'b0;
        step();
        cnt_until(0, 1'b0, 60, n);
        chk("s0_sleep_latency", 32'(n), 32'd30);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (slice_clk[0] !== 1'b0) ok = 1'b0;
        end
        chk("s0_clk_stopped", 32'(ok), 32'h1);

        // ---- table ----
        for (int v = 0; v < 9; v++) begin
            clkreq       = tbl[v].req;
            global_rst_b = tbl[v].grb;
            pwell_pok    = tbl[v].pok;
            repeat (tbl[v].ncyc) step();
            chk($sformatf("tbl%0d_clkack", v), 32'(clkack), 32'(tbl[v].ack));
            chk($sformatf("tbl%0d_clk_off", v), 32'(slice_clk & ~tbl[v].ack), 32'h0);
        end
        chk("proto_err_quiet", 32'(proto_err), 32'h0);

        // ---- slice 6 power override ----
        pwell_pok = '1;
        clkreq    = 7'h52;
        step();
        cnt_until(6, 1'b1, 40, n);
        chk("s6_ack_latency", 32'(n), 32'd20);
        repeat (3) step();
        pwell_pok[6] = 1'b0;
        step();
        chk("s6_pok_ack", 32'(clkack[6]), 32'h0);
        chk("s6_pok_clk", 32'(slice_clk[6]), 32'h0);
        chk("s6_pok_others", 32'(clkack), 32'h12);
        pwell_pok[6] = 1'b1;
        step();
        cnt_until(6, 1'b1, 40, n);
        chk("s6_rewake_latency", 32'(n), 32'd20);

        // ---- usync with slices 1 and 4 on ----
        clkreq[6] = 1'b0;
        repeat (40) step();
        chk("usync_setup_ack", 32'(clkack), 32'h12);
        n = 0;
        while (usync === '0 && n < 40) begin
            step();
            n++;
        end
        chk("usync_first", 32'(usync), 32'h12);
        for (int r = 0; r < 2; r++) begin
            ok = 1'b1;
            for (int k = 0; k < 15; k++) begin
                step();
                if (usync !== '0) ok = 1'b0;
            end
            chk($sformatf("usync_gap%0d", r), 32'(ok), 32'h1);
            step();
            chk($sformatf("usync_pulse%0d", r), 32'(usync), 32'h12);
        end

        // ---- protocol checker ----
`ifdef CCU_PROTO_CHK_EN
        clkreq[3] = 1'b1;
        step();
        tot = 0;
        repeat (5) begin
            step();
            tot++;
        end
        chk("proto_before", 32'(proto_err), 32'h0);
        clkreq[3] = 1'b0;
        step();
        tot++;
        chk("proto_set", 32'(proto_err), 32'h1);
        clkreq[3] = 1'b1;
        step();
        tot++;
        cnt_until(3, 1'b1, 40, n);
        chk("proto_ack_latency", 32'(tot + n), 32'd20);
        repeat (5) step();
        chk("proto_sticky", 32'(proto_err), 32'h1);
`else
        clkreq[3] = 1'b1;
        step();
        repeat (5) step();
        clkreq[3] = 1'b0;
        step();
        clkreq[3] = 1'b1;
        step();
        tot = 7;
        cnt_until(3, 1'b1, 40, n);
        chk("nochk_ack_latency", 32'(tot + n), 32'd20);
        chk("nochk_proto_err", 32'(proto_err), 32'h0);
`endif
        rst = 1'b1;
        step();
        chk("rst2_proto_err", 32'(proto_err), 32'h0);
        chk("rst2_clkack", 32'(clkack), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
